// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue controller sitting between an op stream and an ALU datapath.
// It takes one op at a time from an input stage, holds the ALU operands for the
// op's latency, captures the result and offers it on a valid/ready output port.
// DIVU only loads HiLo inside the datapath, so it produces no result beat; a
// following MFHI/MFLO cannot issue until the divide has fully completed.
// Configuration macro ALU_ISSUE_FIFO_EN: when defined the input stage is a
// 4-entry FIFO, otherwise it is a single holding register.
module alu_issue_ctrl #(
  parameter int         ALU_LAT  = 2,
  parameter int         DIV_LAT  = 33,
  parameter logic [5:0] IDLE_SIG = 6'b111111
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [5:0]  in_op,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] alu_dataA,
  output logic [31:0] alu_dataB,
  output logic [5:0]  alu_signal,
  input  logic [31:0] alu_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_result,
  output logic        out_err,
  output logic        busy
);

  localparam logic [5:0] OP_SLL  = 6'd0;
  localparam logic [5:0] OP_MFHI = 6'd16;
  localparam logic [5:0] OP_MFLO = 6'd18;
  localparam logic [5:0] OP_DIVU = 6'd27;
  localparam logic [5:0] OP_ADD  = 6'd32;
  localparam logic [5:0] OP_SUB  = 6'd34;
  localparam logic [5:0] OP_AND  = 6'd36;
  localparam logic [5:0] OP_OR   = 6'd37;
  localparam logic [5:0] OP_SLT  = 6'd42;

  // The counter must hold the larger of the two latencies (both are >= 1).
  localparam int MAX_LAT = (ALU_LAT > DIV_LAT) ? ALU_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DIVW = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;

  logic             stage_empty;
  logic [5:0]       head_op;
  logic [31:0]      head_a;
  logic [31:0]      head_b;
  logic             push;
  logic             pop;

  function automatic logic is_legal(input logic [5:0] op);
    case (op)
      OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLL,
      OP_SLT, OP_DIVU, OP_MFHI, OP_MFLO: is_legal = 1'b1;
      default:                           is_legal = 1'b0;
    endcase
  endfunction

  // An op leaves the input stage only when the FSM is idle and can take it.
  assign push = in_valid & in_ready;
  assign pop  = (state == IDLE) & ~stage_empty;
  assign busy = ~stage_empty | (state != IDLE);

`ifdef ALU_ISSUE_FIFO_EN
  logic [5:0]  fifo_op [4];
  logic [31:0] fifo_a  [4];
  logic [31:0] fifo_b  [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;

  // Full means not ready, even in a cycle where the FSM pops the head.
  assign stage_empty = (count == 3'd0);
  assign in_ready    = (count != 3'd4);
  assign head_op     = fifo_op[rd_ptr];
  assign head_a      = fifo_a[rd_ptr];
  assign head_b      = fifo_b[rd_ptr];

  // FIFO storage and 2-bit pointers that wrap naturally modulo 4.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (push) begin
        fifo_op[wr_ptr] <= in_op;
        fifo_a[wr_ptr]  <= in_a;
        fifo_b[wr_ptr]  <= in_b;
        wr_ptr          <= wr_ptr + 2'd1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 2'd1;
      end
      case ({push, pop})
        2'b10:   count <= count + 3'd1;
        2'b01:   count <= count - 3'd1;
        default: count <= count;
      endcase
    end
  end
`else
  logic        stage_valid;
  logic [5:0]  stage_op;
  logic [31:0] stage_a;
  logic [31:0] stage_b;

  // A single register only accepts when empty, so push and pop never coincide.
  assign stage_empty = ~stage_valid;
  assign in_ready    = ~stage_valid;
  assign head_op     = stage_op;
  assign head_a      = stage_a;
  assign head_b      = stage_b;

  // Single-entry holding register for the next op.
  always_ff @(posedge clk) begin
    if (reset) begin
      stage_valid <= 1'b0;
      stage_op    <= 6'd0;
      stage_a     <= 32'd0;
      stage_b     <= 32'd0;
    end else if (push) begin
      stage_valid <= 1'b1;
      stage_op    <= in_op;
      stage_a     <= in_a;
      stage_b     <= in_b;
    end else if (pop) begin
      stage_valid <= 1'b0;
    end
  end
`endif

  // Issue FSM: drives the ALU inputs, times the op and owns the output beat.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      alu_dataA  <= 32'd0;
      alu_dataB  <= 32'd0;
      alu_signal <= IDLE_SIG;
      out_valid  <= 1'b0;
      out_result <= 32'd0;
      out_err    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!stage_empty) begin
            if (is_legal(head_op)) begin
              alu_dataA  <= head_a;
              alu_dataB  <= head_b;
              alu_signal <= head_op;
              if (head_op == OP_DIVU) begin
                cnt   <= CNT_W'(DIV_LAT);
                state <= DIVW;
              end else begin
                cnt   <= CNT_W'(ALU_LAT);
                state <= EXEC;
              end
            end else begin
              alu_signal <= IDLE_SIG;
              out_result <= 32'd0;
              out_err    <= 1'b1;
              out_valid  <= 1'b1;
              state      <= HOLD;
            end
          end else begin
            alu_signal <= IDLE_SIG;
          end
        end
        EXEC: begin
          if (cnt == CNT_W'(1)) begin
            out_result <= alu_result;
            out_err    <= 1'b0;
            out_valid  <= 1'b1;
            alu_signal <= IDLE_SIG;
            state      <= HOLD;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        DIVW: begin
          if (cnt == CNT_W'(1)) begin
            alu_signal <= IDLE_SIG;
            state      <= IDLE;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        HOLD: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: scoreboard bench for alu_issue_ctrl.
// Directed ops push their hand-computed result into a queue; a monitor pops and
// compares on every output beat. A small ALU/HiLo datapath model answers the DUT.
// Compile with ALU_ISSUE_FIFO_EN defined to exercise the 4-entry input FIFO.
module tb_alu_issue_ctrl;

  localparam int         ALU_LAT  = 2;
  localparam int         DIV_LAT  = 33;
  localparam logic [5:0] IDLE_SIG = 6'b111111;
`ifdef ALU_ISSUE_FIFO_EN
  localparam int NSTAGE = 5;
`else
  localparam int NSTAGE = 2;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_op;
  logic [31:0] in_a;
  logic [31:0] in_b;
  logic [31:0] alu_dataA;
  logic [31:0] alu_dataB;
  logic [5:0]  alu_signal;
  logic [31:0] alu_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_result;
  logic        out_err;
  logic        busy;

  typedef struct {
    logic [31:0] res;
    logic        err;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   beats    = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  alu_issue_ctrl #(.ALU_LAT(ALU_LAT), .DIV_LAT(DIV_LAT), .IDLE_SIG(IDLE_SIG)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_a(in_a), .in_b(in_b),
    .alu_dataA(alu_dataA), .alu_dataB(alu_dataB), .alu_signal(alu_signal),
    .alu_result(alu_result), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_err(out_err), .busy(busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  // Datapath model: one register stage (valid in the 2nd applied cycle) and a
  // HiLo pair written only after DIV_LAT consecutive DIVU cycles.
  logic [31:0] res_q, hi_q, lo_q;
  int          div_cnt;
  assign alu_result = res_q;

  always @(posedge clk) begin
    if (reset) begin
      res_q <= 32'd0; hi_q <= 32'd0; lo_q <= 32'd0; div_cnt <= 0;
    end else begin
      case (alu_signal)
        6'd36:   res_q <= alu_dataA & alu_dataB;
        6'd37:   res_q <= alu_dataA | alu_dataB;
        6'd32:   res_q <= alu_dataA + alu_dataB;
        6'd34:   res_q <= alu_dataA - alu_dataB;
        6'd0:    res_q <= alu_dataA << alu_dataB[4:0];
        6'd42:   res_q <= {31'd0, $signed(alu_dataA) < $signed(alu_dataB)};
        6'd16:   res_q <= hi_q;
        6'd18:   res_q <= lo_q;
        default: res_q <= 32'hDEADBEEF;
      endcase
      if (alu_signal == 6'd27) begin
        if (div_cnt == DIV_LAT - 1) begin
          hi_q    <= (alu_dataB == 0) ? alu_dataA : alu_dataA % alu_dataB;
          lo_q    <= (alu_dataB == 0) ? 32'hFFFFFFFF : alu_dataA / alu_dataB;
          div_cnt <= 0;
        end else begin
          div_cnt <= div_cnt + 1;
        end
      end else begin
        div_cnt <= 0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic expectBeat(input logic [31:0] res, input logic err);
    exp_t e;
    e.res = res;
    e.err = err;
    exp_q.push_back(e);
  endtask

  // Present one op and hold it until the DUT takes it; returns cycles spent waiting.
  task automatic applyStimulus(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, output int waits);
    logic accepted;
    accepted = 1'b0;
    waits    = 0;
    in_op    = op;
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    while (!accepted && waits < 200) begin
      @(negedge clk);
      accepted = (in_ready === 1'b1);
      @(posedge clk);
      #1;
      if (!accepted) waits++;
    end
    in_valid = 1'b0;
    if (!accepted) begin
      checks++;
      failures++;
      $display("[TB] FAIL input accept timeout: op %0d not taken, expected acceptance", op);
    end
  endtask

  task automatic waitIdle(input int limit, output int n);
    n = 0;
    while (busy !== 1'b0 && n < limit) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (busy !== 1'b0) begin
      checks++;
      failures++;
      $display("[TB] FAIL idle timeout: busy %b, expected 0", busy);
    end
  endtask

  // Monitor: every presented beat must match the queue head; pop on acceptance.
  always @(negedge clk) begin
    if (reset === 1'b0 && out_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected beat", {31'd0, out_valid}, 32'd0);
      end else begin
        checkOutput("beat result", out_result, exp_q[0].res);
        checkOutput("beat err", {31'd0, out_err}, {31'd0, exp_q[0].err});
        if (out_ready === 1'b1) begin
          void'(exp_q.pop_front());
          beats++;
        end
      end
    end
  end

  // Watch the ALU opcode bus for ordering and illegal-opcode leakage.
  int         div_seen  = -1;
  int         mfhi_seen = -1;
  logic       saw_three = 1'b0;
  logic [5:0] prev_sig  = IDLE_SIG;
  always @(negedge clk) begin
    if (alu_signal == 6'd3) saw_three = 1'b1;
    if (alu_signal == 6'd27 && prev_sig != 6'd27 && div_seen < 0) div_seen = cyc;
    if (alu_signal == 6'd16 && prev_sig != 6'd16 && mfhi_seen < 0) mfhi_seen = cyc;
    prev_sig = alu_signal;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int w, n, beats_before;
    logic [5:0]  s_op  [5] = '{6'd36, 6'd37, 6'd34, 6'd0, 6'd32};
    logic [31:0] s_a   [5] = '{32'd12, 32'd12, 32'd5, 32'd1, 32'hFFFFFFFF};
    logic [31:0] s_b   [5] = '{32'd10, 32'd10, 32'd9, 32'd4, 32'd1};
    logic [31:0] s_res [5] = '{32'd8, 32'd14, 32'hFFFFFFFC, 32'd16, 32'd0};

    in_valid = 1'b0; in_op = 6'd0; in_a = 32'd0; in_b = 32'd0;
    out_ready = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset out_result", out_result, 32'd0);
    checkOutput("reset out_err", {31'd0, out_err}, 32'd0);
    checkOutput("reset alu_dataA", alu_dataA, 32'd0);
    checkOutput("reset alu_dataB", alu_dataB, 32'd0);
    checkOutput("reset alu_signal", {26'd0, alu_signal}, {26'd0, IDLE_SIG});
    checkOutput("reset busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    // ADD 7 + -3 = 4; out_valid appears ALU_LAT+1 edges after acceptance.
    $display("[TB] ADD latency test");
    out_ready = 1'b1;
    expectBeat(32'd4, 1'b0);
    applyStimulus(6'd32, 32'd7, 32'hFFFFFFFD, w);
    @(posedge clk);
    #1;
    n = 1;
    checkOutput("add alu_signal", {26'd0, alu_signal}, 32'd32);
    checkOutput("add alu_dataA", alu_dataA, 32'd7);
    checkOutput("add alu_dataB", alu_dataB, 32'hFFFFFFFD);
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("add latency", n, ALU_LAT + 1);
    waitIdle(50, n);

    // DIVU 100/7 then MFHI (rem 2) and MFLO (quot 14); DIVU itself gives no beat.
    $display("[TB] DIVU / MFHI / MFLO test");
    applyStimulus(6'd27, 32'd100, 32'd7, w);
    expectBeat(32'd2, 1'b0);
    applyStimulus(6'd16, 32'd0, 32'd0, w);
    expectBeat(32'd14, 1'b0);
    applyStimulus(6'd18, 32'd0, 32'd0, w);
    waitIdle(300, n);
    checkOutput("mfhi waits for divide", {31'd0, (div_seen >= 0) && (mfhi_seen - div_seen >= DIV_LAT)}, 32'd1);

    // DIVU by zero still occupies the full divide latency.
    $display("[TB] DIVU by zero test");
    applyStimulus(6'd27, 32'd5, 32'd0, w);
    waitIdle(100, n);
    checkOutput("divu by zero duration", n, DIV_LAT + 1);

    // Illegal opcode 3 yields result 0 with the error flag set.
    $display("[TB] illegal opcode test");
    expectBeat(32'd0, 1'b1);
    applyStimulus(6'd3, 32'd9, 32'd9, w);
    waitIdle(50, n);

    // SLT -5 < 3 = 1, held for 10 stalled cycles then released once.
    $display("[TB] output stall test");
    out_ready = 1'b0;
    expectBeat(32'd1, 1'b0);
    applyStimulus(6'd42, 32'hFFFFFFFB, 32'd3, w);
    n = 0;
    while (out_valid !== 1'b1 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      checkOutput("stall busy", {31'd0, busy}, 32'd1);
      checkOutput("stall out_valid", {31'd0, out_valid}, 32'd1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("single beat on release", {31'd0, out_valid}, 32'd0);
    waitIdle(50, n);

    // Fill the input stage while the output is stalled; results must stay ordered.
    $display("[TB] input stage fill test, %0d ops", NSTAGE);
    out_ready = 1'b0;
    for (int i = 0; i < NSTAGE; i++) begin
      expectBeat(s_res[i], 1'b0);
      applyStimulus(s_op[i], s_a[i], s_b[i], w);
`ifdef ALU_ISSUE_FIFO_EN
      checkOutput("fifo push without stall", w, 32'd0);
`endif
    end
    checkOutput("in_ready when stage full", {31'd0, in_ready}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("in_ready still low", {31'd0, in_ready}, 32'd0);
    out_ready = 1'b1;
    waitIdle(300, n);

    // Reset in the middle of a divide with an MFLO queued: everything is dropped.
    $display("[TB] reset during DIVW test");
    applyStimulus(6'd27, 32'd50, 32'd5, w);
    applyStimulus(6'd18, 32'd0, 32'd0, w);
    repeat (5) @(posedge clk);
    #1;
    checkOutput("in DIVW before reset", {26'd0, alu_signal}, 32'd27);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("post-reset out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("post-reset busy", {31'd0, busy}, 32'd0);
    checkOutput("post-reset alu_signal", {26'd0, alu_signal}, {26'd0, IDLE_SIG});
    checkOutput("post-reset in_ready", {31'd0, in_ready}, 32'd1);
    beats_before = beats;
    repeat (60) @(posedge clk);
    #1;
    checkOutput("no late beat", beats, beats_before);

    checkOutput("scoreboard drained", exp_q.size(), 32'd0);
    checkOutput("alu_signal never 3", {31'd0, saw_three}, 32'd0);
    checkOutput("total beats", beats, 5 + NSTAGE);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_issue_ctrl.md
ALU_ISSUE_CTRL -- requirements
Module: alu_issue_ctrl

Interface
REQ-001 SHALL have parameter ALU_LAT, default 2: cycles from alu_signal/operands applied to a valid ALU/shifter/HiLo-read result.
REQ-002 SHALL have parameter DIV_LAT, default 33: cycles from DIVU applied until HiLo holds the quotient/remainder.
REQ-003 SHALL have parameter IDLE_SIG, default 6'b111111: opcode driven on alu_signal when no operation is in execution.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 in_valid  input  1  upstream op available.
REQ-007 in_ready  output  1  block accepts op this cycle.
REQ-008 in_op  input  6  opcode: AND 36, OR 37, ADD 32, SUB 34, SLL 0, SLT 42, DIVU 27, MFHI 16, MFLO 18.
REQ-009 in_a, in_b  input  32 each  signed operands.
REQ-010 alu_dataA, alu_dataB  output  32 each  operands to ALU datapath.
REQ-011 alu_signal  output  6  opcode to ALU datapath.
REQ-012 alu_result  input  32  ALU datapath Output.
REQ-013 out_valid  output  1  result beat available.
REQ-014 out_ready  input  1  downstream accepts result.
REQ-015 out_result  output  32  captured result; out_err  output  1  illegal opcode flag.
REQ-016 busy  output  1  high when any op is queued, executing or held.

Function
REQ-017 Handshake: transfer on in_valid & in_ready (input) and out_valid & out_ready (output); out_valid/out_result/out_err SHALL stay stable until accepted.
REQ-018 FSM states IDLE, EXEC, DIVW, HOLD; exactly one op in flight.
REQ-019 IDLE: if an op is pending, load alu_dataA/alu_dataB/alu_signal from it, pop it, load counter, go EXEC (legal non-DIVU) or DIVW (DIVU); else drive IDLE_SIG.
REQ-020 EXEC: hold ALU inputs for ALU_LAT cycles, capture alu_result into out_result at the final cycle, assert out_valid next cycle, go HOLD.
REQ-021 DIVW: hold inputs for DIV_LAT cycles, produce no result beat, return to IDLE; a following MFHI/MFLO SHALL NOT issue before DIVW completes.
REQ-022 HOLD: on out_ready deassert out_valid and go IDLE same edge; next op issues the following cycle.
REQ-023 Illegal opcode: not driven to ALU; go directly to HOLD with out_result 0, out_err 1; legal ops give out_err 0.
REQ-024 DIVU with in_b 0 SHALL still wait full DIV_LAT; no special handling.
REQ-025 Input stage full: in_ready 0; no same-cycle bypass of a full stage even if a pop occurs.
REQ-026 Counter SHALL count ALU_LAT or DIV_LAT down to 1 exactly; no wrap.
REQ-027 busy = stage not empty | state != IDLE.

Reset
REQ-028 On reset: state IDLE, input stage empty, in_ready 1, out_valid 0, out_result 0, out_err 0, alu_dataA/alu_dataB 0, alu_signal IDLE_SIG, busy 0.
REQ-029 Reset mid-operation SHALL discard in-flight, queued and held ops with no output beat; ALU datapath shares the same reset.

Configuration
REQ-030 Macro ALU_ISSUE_FIFO_EN defined: input stage is a 4-entry FIFO, in_ready = not full, order preserved, pointers wrap modulo 4.
REQ-031 ALU_ISSUE_FIFO_EN undefined: input stage is one register, in_ready = register empty; all other behaviour identical.

Verification
REQ-032 ADD 7, -3, out_ready 1 -> single beat out_result 4, out_err 0, out_valid ALU_LAT+1 cycles after issue.
REQ-033 DIVU 100, 7 then MFHI then MFLO -> no DIVU beat; beats 2 then 14 in order, MFHI issued no earlier than DIV_LAT cycles after DIVU.
REQ-034 Opcode 6'b000011 -> beat out_result 0, out_err 1; alu_signal never shows 3.
REQ-035 out_ready 0 for 10 cycles after SLT -5, 3 -> out_result 1 stable throughout, busy 1, one beat on release.
REQ-036 With ALU_ISSUE_FIFO_EN, push 5 ops back-to-back while output stalled -> in_ready falls after 4th queued; all results in order.
REQ-037 Reset asserted during DIVW -> next cycle out_valid 0, busy 0, alu_signal IDLE_SIG, no late beat.
